// File: rtl/sy_ppl_br_pred_nw.sv
// sy_ppl_br_pred_nw - N-wide fetch-stage branch predictor.
//
// Scans FW pre-decoded fetch slots, picks the lowest valid predicted-taken
// slot and squashes everything after it. A same-cycle redirect goes to the
// frontend; the surviving slots and their predicted next PCs are delivered
// to the instruction buffer through a registered valid/ready stage.
// A speculative return address stack is kept alongside a committed copy of
// its pointer/count so a flush can roll the speculative state back. A table
// of 2-bit counters gives dynamic branch direction when BP_MODE = 1.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       pipeline flush from the ROB
//   in_vld_i / in_rdy_o           per-slot valid in, packet ready out
//   pc_i, type_i, is_c_i,
//   imm_neg_i, target_i           per-slot pre-decode information
//   btb_vld_i, btb_target_i       BTB hit and target for indirect jumps
//   bht_upd_*                     resolved branch direction update
//   ras_cmt_push_i/pop_i          committed call/return
//   bp_vld_o, bp_addr_o           combinational frontend redirect
//   out_vld_o / out_rdy_i         registered packet handshake
//   out_slot_vld_o, out_pc_o,
//   out_npc_o                     surviving slots, PCs, predicted next PCs
module sy_ppl_br_pred_nw #(
  parameter int FW          = 4,
  parameter int VAW         = 39,
  parameter int RAS_DEPTH   = 8,
  parameter int BHT_ENTRIES = 256,
  parameter int BP_MODE     = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [FW-1:0]     in_vld_i,
  output logic              in_rdy_o,
  input  logic [FW*VAW-1:0] pc_i,
  input  logic [FW*3-1:0]   type_i,
  input  logic [FW-1:0]     is_c_i,
  input  logic [FW-1:0]     imm_neg_i,
  input  logic [FW*VAW-1:0] target_i,
  input  logic              btb_vld_i,
  input  logic [VAW-1:0]    btb_target_i,
  input  logic              bht_upd_vld_i,
  input  logic [VAW-1:0]    bht_upd_pc_i,
  input  logic              bht_upd_taken_i,
  input  logic              ras_cmt_push_i,
  input  logic              ras_cmt_pop_i,
  output logic              bp_vld_o,
  output logic [VAW-1:0]    bp_addr_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [FW-1:0]     out_slot_vld_o,
  output logic [FW*VAW-1:0] out_pc_o,
  output logic [FW*VAW-1:0] out_npc_o
);

  localparam int RAS_AW = $clog2(RAS_DEPTH);
  localparam int BHT_AW = $clog2(BHT_ENTRIES);

  localparam logic [2:0] T_BRANCH    = 3'd1;
  localparam logic [2:0] T_JUMP      = 3'd2;
  localparam logic [2:0] T_JALR      = 3'd3;
  localparam logic [2:0] T_CALL_JAL  = 3'd4;
  localparam logic [2:0] T_CALL_JALR = 3'd5;
  localparam logic [2:0] T_RET       = 3'd6;
  localparam logic [2:0] T_NONE      = 3'd0;

  localparam logic [RAS_AW-1:0] PTR_ONE  = RAS_AW'(1);
  localparam logic [RAS_AW:0]   CNT_ONE  = (RAS_AW+1)'(1);
  localparam logic [RAS_AW:0]   CNT_ZERO = (RAS_AW+1)'(0);
  localparam logic [RAS_AW:0]   CNT_FULL = (RAS_AW+1)'(RAS_DEPTH);

  // 2-bit saturating counter step
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
    return res;
  endfunction

  // State
  logic [VAW-1:0]    ras_mem_r [RAS_DEPTH];
  logic [RAS_AW-1:0] spec_tos_r;
  logic [RAS_AW:0]   spec_cnt_r;
  logic [RAS_AW-1:0] cmt_tos_r;
  logic [RAS_AW:0]   cmt_cnt_r;
  logic [1:0]        bht_r [BHT_ENTRIES];
  logic              out_vld_r;
  logic [FW-1:0]     out_slot_vld_r;
  logic [FW*VAW-1:0] out_pc_r;
  logic [FW*VAW-1:0] out_npc_r;

  // Combinational
  logic              fire_s;
  logic              accept_s;
  logic [VAW-1:0]    ras_top_s;
  logic              ras_empty_s;
  logic [VAW-1:0]    fall_s [FW];
  logic [VAW-1:0]    tgt_s [FW];
  logic [FW-1:0]     taken_s;
  logic              seen_s;
  logic              win_vld_s;
  logic [VAW-1:0]    win_tgt_s;
  logic [VAW-1:0]    win_fall_s;
  logic [2:0]        win_type_s;
  logic [FW-1:0]     keep_s;
  logic [FW*VAW-1:0] npc_s;
  logic              bp_vld_s;
  logic              spec_push_s;
  logic              spec_pop_s;
  logic [RAS_AW-1:0] cmt_tos_n_s;
  logic [RAS_AW:0]   cmt_cnt_n_s;
  logic [RAS_AW-1:0] spec_tos_n_s;
  logic [RAS_AW:0]   spec_cnt_n_s;
  logic [BHT_AW-1:0] bht_upd_idx_s;
  logic              unused_s;

  assign in_rdy_o      = !out_vld_r || out_rdy_i;
  assign fire_s        = (|in_vld_i) && in_rdy_o;
  // A flush in the same cycle drops the fire entirely.
  assign accept_s      = fire_s && !flush_i;
  assign ras_top_s     = ras_mem_r[spec_tos_r - PTR_ONE];
  assign ras_empty_s   = (spec_cnt_r == CNT_ZERO);
  assign bht_upd_idx_s = bht_upd_pc_i[BHT_AW:1];
  assign unused_s      = ^{bht_upd_pc_i, imm_neg_i};

  // Per-slot fall-through, taken decision and predicted target
  always_comb begin
    for (int i = 0; i < FW; i++) begin
      fall_s[i]  = pc_i[i*VAW +: VAW] + (is_c_i[i] ? VAW'(2) : VAW'(4));
      taken_s[i] = 1'b0;
      tgt_s[i]   = fall_s[i];
      case (type_i[i*3 +: 3])
        T_BRANCH: begin
          taken_s[i] = (BP_MODE == 0) ? imm_neg_i[i] : bht_r[pc_i[i*VAW+1 +: BHT_AW]][1];
          tgt_s[i]   = target_i[i*VAW +: VAW];
        end
        T_JUMP, T_CALL_JAL: begin
          taken_s[i] = 1'b1;
          tgt_s[i]   = target_i[i*VAW +: VAW];
        end
        T_JALR, T_CALL_JALR: begin
          taken_s[i] = 1'b1;
          tgt_s[i]   = btb_vld_i ? btb_target_i : fall_s[i];
        end
        T_RET: begin
          // An empty stack gives no prediction; the scan moves on.
          taken_s[i] = !ras_empty_s;
          tgt_s[i]   = ras_top_s;
        end
        T_NONE: begin
          taken_s[i] = 1'b0;
          tgt_s[i]   = fall_s[i];
        end
        default: begin
          taken_s[i] = 1'b0;
          tgt_s[i]   = fall_s[i];
        end
      endcase
    end
  end

  // Winner scan: lowest valid taken slot, later slots squashed
  always_comb begin
    seen_s     = 1'b0;
    win_tgt_s  = '0;
    win_fall_s = '0;
    win_type_s = T_NONE;
    keep_s     = '0;
    npc_s      = '0;
    for (int j = 0; j < FW; j++) begin
      keep_s[j] = in_vld_i[j] && !seen_s;
      if (in_vld_i[j] && taken_s[j] && !seen_s) begin
        seen_s                = 1'b1;
        win_tgt_s             = tgt_s[j];
        win_fall_s            = fall_s[j];
        win_type_s            = type_i[j*3 +: 3];
        npc_s[j*VAW +: VAW]   = tgt_s[j];
      end else begin
        npc_s[j*VAW +: VAW]   = fall_s[j];
      end
    end
    win_vld_s = seen_s;
  end

  // Frontend redirect and speculative RAS op selection
  always_comb begin
    bp_vld_s    = accept_s && win_vld_s;
    spec_push_s = bp_vld_s && ((win_type_s == T_CALL_JAL) || (win_type_s == T_CALL_JALR));
    spec_pop_s  = bp_vld_s && (win_type_s == T_RET);
    if (bp_vld_s) begin
      bp_addr_o = win_tgt_s;
    end else begin
      bp_addr_o = '0;
    end
  end
  assign bp_vld_o = bp_vld_s;

  // Next committed and speculative RAS pointer/count
  always_comb begin
    cmt_tos_n_s = cmt_tos_r;
    cmt_cnt_n_s = cmt_cnt_r;
    // A simultaneous committed push and pop cancel out.
    if (ras_cmt_push_i && !ras_cmt_pop_i) begin
      cmt_tos_n_s = cmt_tos_r + PTR_ONE;
      cmt_cnt_n_s = (cmt_cnt_r == CNT_FULL) ? cmt_cnt_r : cmt_cnt_r + CNT_ONE;
    end else if (ras_cmt_pop_i && !ras_cmt_push_i && (cmt_cnt_r != CNT_ZERO)) begin
      cmt_tos_n_s = cmt_tos_r - PTR_ONE;
      cmt_cnt_n_s = cmt_cnt_r - CNT_ONE;
    end else begin
      cmt_tos_n_s = cmt_tos_r;
      cmt_cnt_n_s = cmt_cnt_r;
    end

    spec_tos_n_s = spec_tos_r;
    spec_cnt_n_s = spec_cnt_r;
    if (flush_i) begin
      spec_tos_n_s = cmt_tos_n_s;
      spec_cnt_n_s = cmt_cnt_n_s;
    end else if (spec_push_s) begin
      spec_tos_n_s = spec_tos_r + PTR_ONE;
      spec_cnt_n_s = (spec_cnt_r == CNT_FULL) ? spec_cnt_r : spec_cnt_r + CNT_ONE;
    end else if (spec_pop_s) begin
      spec_tos_n_s = spec_tos_r - PTR_ONE;
      spec_cnt_n_s = spec_cnt_r - CNT_ONE;
    end else begin
      spec_tos_n_s = spec_tos_r;
      spec_cnt_n_s = spec_cnt_r;
    end
  end

  // RAS pointers and counts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_tos_r <= '0;
      spec_cnt_r <= '0;
      cmt_tos_r  <= '0;
      cmt_cnt_r  <= '0;
    end else begin
      spec_tos_r <= spec_tos_n_s;
      spec_cnt_r <= spec_cnt_n_s;
      cmt_tos_r  <= cmt_tos_n_s;
      cmt_cnt_r  <= cmt_cnt_n_s;
    end
  end

  // RAS storage; a push when full overwrites the oldest slot via wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < RAS_DEPTH; k++) begin
        ras_mem_r[k] <= '0;
      end
    end else if (spec_push_s) begin
      ras_mem_r[spec_tos_r] <= win_fall_s;
    end
  end

  // Branch history counters, untouched by flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < BHT_ENTRIES; k++) begin
        bht_r[k] <= 2'b01;
      end
    end else if (bht_upd_vld_i) begin
      bht_r[bht_upd_idx_s] <= bht_next(bht_r[bht_upd_idx_s], bht_upd_taken_i);
    end
  end

  // Output packet register with valid/ready hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_r      <= 1'b0;
      out_slot_vld_r <= '0;
      out_pc_r       <= '0;
      out_npc_r      <= '0;
    end else if (flush_i) begin
      out_vld_r      <= 1'b0;
    end else if (fire_s) begin
      out_vld_r      <= 1'b1;
      out_slot_vld_r <= keep_s;
      out_pc_r       <= pc_i;
      out_npc_r      <= npc_s;
    end else if (out_rdy_i) begin
      out_vld_r      <= 1'b0;
    end
  end

  assign out_vld_o      = out_vld_r;
  assign out_slot_vld_o = out_slot_vld_r;
  assign out_pc_o       = out_pc_r;
  assign out_npc_o      = out_npc_r;

endmodule

// File: tb/tb_sy_ppl_br_pred_nw.sv
// Directed bench for sy_ppl_br_pred_nw. Two instances share stimulus: one
// with the counter-based branch policy and one with the static policy.
module tb_sy_ppl_br_pred_nw;

  localparam int FW  = 4;
  localparam int VAW = 39;

  localparam logic [2:0] T_NONE      = 3'd0;
  localparam logic [2:0] T_BRANCH    = 3'd1;
  localparam logic [2:0] T_JUMP      = 3'd2;
  localparam logic [2:0] T_JALR      = 3'd3;
  localparam logic [2:0] T_CALL_JAL  = 3'd4;
  localparam logic [2:0] T_RET       = 3'd6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [FW-1:0]     in_vld;
  logic [FW*VAW-1:0] pc;
  logic [FW*3-1:0]   typ;
  logic [FW-1:0]     is_c;
  logic [FW-1:0]     imm_neg;
  logic [FW*VAW-1:0] tgt;
  logic              btb_vld;
  logic [VAW-1:0]    btb_tgt;
  logic              bht_upd_vld;
  logic [VAW-1:0]    bht_upd_pc;
  logic              bht_upd_taken;
  logic              cmt_push;
  logic              cmt_pop;
  logic              out_rdy;

  logic              in_rdy_m1, in_rdy_m0;
  logic              bp_vld_m1, bp_vld_m0;
  logic [VAW-1:0]    bp_addr_m1, bp_addr_m0;
  logic              out_vld_m1, out_vld_m0;
  logic [FW-1:0]     slot_vld_m1, slot_vld_m0;
  logic [FW*VAW-1:0] out_pc_m1, out_pc_m0;
  logic [FW*VAW-1:0] out_npc_m1, out_npc_m0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sy_ppl_br_pred_nw #(.FW(FW), .VAW(VAW), .RAS_DEPTH(8), .BHT_ENTRIES(256), .BP_MODE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_vld_i(in_vld), .in_rdy_o(in_rdy_m1),
    .pc_i(pc), .type_i(typ), .is_c_i(is_c), .imm_neg_i(imm_neg), .target_i(tgt),
    .btb_vld_i(btb_vld), .btb_target_i(btb_tgt), .bht_upd_vld_i(bht_upd_vld),
    .bht_upd_pc_i(bht_upd_pc), .bht_upd_taken_i(bht_upd_taken),
    .ras_cmt_push_i(cmt_push), .ras_cmt_pop_i(cmt_pop),
    .bp_vld_o(bp_vld_m1), .bp_addr_o(bp_addr_m1), .out_vld_o(out_vld_m1), .out_rdy_i(out_rdy),
    .out_slot_vld_o(slot_vld_m1), .out_pc_o(out_pc_m1), .out_npc_o(out_npc_m1)
  );

  sy_ppl_br_pred_nw #(.FW(FW), .VAW(VAW), .RAS_DEPTH(8), .BHT_ENTRIES(256), .BP_MODE(0)) dut_static (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_vld_i(in_vld), .in_rdy_o(in_rdy_m0),
    .pc_i(pc), .type_i(typ), .is_c_i(is_c), .imm_neg_i(imm_neg), .target_i(tgt),
    .btb_vld_i(btb_vld), .btb_target_i(btb_tgt), .bht_upd_vld_i(bht_upd_vld),
    .bht_upd_pc_i(bht_upd_pc), .bht_upd_taken_i(bht_upd_taken),
    .ras_cmt_push_i(cmt_push), .ras_cmt_pop_i(cmt_pop),
    .bp_vld_o(bp_vld_m0), .bp_addr_o(bp_addr_m0), .out_vld_o(out_vld_m0), .out_rdy_i(out_rdy),
    .out_slot_vld_o(slot_vld_m0), .out_pc_o(out_pc_m0), .out_npc_o(out_npc_m0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    flush = 1'b0; in_vld = '0; pc = '0; typ = '0; is_c = '0; imm_neg = '0; tgt = '0;
    btb_vld = 1'b0; btb_tgt = '0; bht_upd_vld = 1'b0; bht_upd_pc = '0; bht_upd_taken = 1'b0;
    cmt_push = 1'b0; cmt_pop = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [VAW-1:0] p, input logic [2:0] t,
                          input logic c, input logic n, input logic [VAW-1:0] tg);
    in_vld[i]            = 1'b1;
    pc[i*VAW +: VAW]     = p;
    typ[i*3 +: 3]        = t;
    is_c[i]              = c;
    imm_neg[i]           = n;
    tgt[i*VAW +: VAW]    = tg;
  endtask

  task automatic test_reset();
    n_checks++; if (out_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %0b expected 0", out_vld_m1); end
    n_checks++; if (slot_vld_m1 !== 4'b0000) begin n_fail++; $display("FAIL reset_slot_vld: got %b expected 0000", slot_vld_m1); end
    n_checks++; if (out_pc_m1 !== '0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", out_pc_m1); end
    n_checks++; if (out_npc_m1 !== '0) begin n_fail++; $display("FAIL reset_out_npc: got %h expected 0", out_npc_m1); end
    n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL reset_bp_vld: got %0b expected 0", bp_vld_m1); end
    n_checks++; if (in_rdy_m1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %0b expected 1", in_rdy_m1); end
  endtask

  task automatic test_jump();
    clr_in(); out_rdy = 1'b1;
    set_slot(0, 39'h1000, T_NONE, 1'b0, 1'b0, 39'h0);
    set_slot(1, 39'h1004, T_JUMP, 1'b0, 1'b0, 39'h2000);
    set_slot(2, 39'h1008, T_NONE, 1'b0, 1'b0, 39'h0);
    set_slot(3, 39'h100C, T_JUMP, 1'b0, 1'b0, 39'h2222);
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b1) begin n_fail++; $display("FAIL jump_bp_vld: got %0b expected 1", bp_vld_m1); end
    n_checks++; if (bp_addr_m1 !== 39'h2000) begin n_fail++; $display("FAIL jump_bp_addr: got %h expected 2000", bp_addr_m1); end
    tick();
    n_checks++; if (out_vld_m1 !== 1'b1) begin n_fail++; $display("FAIL jump_out_vld: got %0b expected 1", out_vld_m1); end
    n_checks++; if (slot_vld_m1 !== 4'b0011) begin n_fail++; $display("FAIL jump_slot_vld: got %b expected 0011", slot_vld_m1); end
    n_checks++; if (out_npc_m1[1*VAW +: VAW] !== 39'h2000) begin n_fail++; $display("FAIL jump_npc1: got %h expected 2000", out_npc_m1[1*VAW +: VAW]); end
    n_checks++; if (out_npc_m1[0 +: VAW] !== 39'h1004) begin n_fail++; $display("FAIL jump_npc0: got %h expected 1004", out_npc_m1[0 +: VAW]); end
    n_checks++; if (out_npc_m1[3*VAW +: VAW] !== 39'h1010) begin n_fail++; $display("FAIL jump_npc3: got %h expected 1010", out_npc_m1[3*VAW +: VAW]); end
    n_checks++; if (out_pc_m1[2*VAW +: VAW] !== 39'h1008) begin n_fail++; $display("FAIL jump_pc2: got %h expected 1008", out_pc_m1[2*VAW +: VAW]); end
    clr_in(); tick();
    n_checks++; if (out_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL jump_drain: got %0b expected 0", out_vld_m1); end
  endtask

  task automatic test_jalr();
    clr_in(); out_rdy = 1'b1;
    set_slot(0, 39'h1200, T_JALR, 1'b0, 1'b0, 39'h0);
    btb_vld = 1'b1; btb_tgt = 39'hABC0;
    #1;
    n_checks++; if (bp_addr_m1 !== 39'hABC0) begin n_fail++; $display("FAIL jalr_btb: got %h expected abc0", bp_addr_m1); end
    btb_vld = 1'b0;
    #1;
    n_checks++; if (bp_addr_m1 !== 39'h1204) begin n_fail++; $display("FAIL jalr_nobtb: got %h expected 1204", bp_addr_m1); end
    tick(); clr_in(); tick();
  endtask

  task automatic test_call_ret();
    clr_in(); out_rdy = 1'b1;
    set_slot(0, 39'h1000, T_CALL_JAL, 1'b1, 1'b0, 39'h3000);
    #1;
    n_checks++; if (bp_addr_m1 !== 39'h3000) begin n_fail++; $display("FAIL call_bp_addr: got %h expected 3000", bp_addr_m1); end
    tick();
    clr_in(); set_slot(0, 39'h3010, T_RET, 1'b0, 1'b0, 39'h0);
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b1) begin n_fail++; $display("FAIL ret_bp_vld: got %0b expected 1", bp_vld_m1); end
    n_checks++; if (bp_addr_m1 !== 39'h1002) begin n_fail++; $display("FAIL ret_bp_addr: got %h expected 1002", bp_addr_m1); end
    tick();
    n_checks++; if (out_npc_m1[0 +: VAW] !== 39'h1002) begin n_fail++; $display("FAIL ret_npc: got %h expected 1002", out_npc_m1[0 +: VAW]); end
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL ret_empty_bp_vld: got %0b expected 0", bp_vld_m1); end
    n_checks++; if (bp_addr_m1 !== 39'h0) begin n_fail++; $display("FAIL ret_empty_bp_addr: got %h expected 0", bp_addr_m1); end
    tick();
    n_checks++; if (out_npc_m1[0 +: VAW] !== 39'h3014) begin n_fail++; $display("FAIL ret_empty_npc: got %h expected 3014", out_npc_m1[0 +: VAW]); end
    n_checks++; if (slot_vld_m1 !== 4'b0001) begin n_fail++; $display("FAIL ret_empty_slot: got %b expected 0001", slot_vld_m1); end
    clr_in(); tick();
  endtask

  task automatic test_back_to_back();
    clr_in(); out_rdy = 1'b1;
    set_slot(0, 39'h4000, T_NONE, 1'b0, 1'b0, 39'h0);
    tick();
    n_checks++; if (out_pc_m1[0 +: VAW] !== 39'h4000) begin n_fail++; $display("FAIL stall_load_a: got %h expected 4000", out_pc_m1[0 +: VAW]); end
    out_rdy = 1'b0;
    clr_in(); set_slot(0, 39'h5000, T_JUMP, 1'b0, 1'b0, 39'h6000);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (in_rdy_m1 !== 1'b0) begin n_fail++; $display("FAIL stall_in_rdy[%0d]: got %0b expected 0", c, in_rdy_m1); end
      n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL stall_bp_vld[%0d]: got %0b expected 0", c, bp_vld_m1); end
      tick();
      n_checks++; if (out_vld_m1 !== 1'b1) begin n_fail++; $display("FAIL stall_out_vld[%0d]: got %0b expected 1", c, out_vld_m1); end
      n_checks++; if (out_pc_m1[0 +: VAW] !== 39'h4000) begin n_fail++; $display("FAIL stall_hold_pc[%0d]: got %h expected 4000", c, out_pc_m1[0 +: VAW]); end
      n_checks++; if (out_npc_m1[0 +: VAW] !== 39'h4004) begin n_fail++; $display("FAIL stall_hold_npc[%0d]: got %h expected 4004", c, out_npc_m1[0 +: VAW]); end
    end
    out_rdy = 1'b1;
    #1;
    n_checks++; if (in_rdy_m1 !== 1'b1) begin n_fail++; $display("FAIL release_in_rdy: got %0b expected 1", in_rdy_m1); end
    n_checks++; if (bp_addr_m1 !== 39'h6000) begin n_fail++; $display("FAIL release_bp_addr: got %h expected 6000", bp_addr_m1); end
    tick();
    n_checks++; if (out_pc_m1[0 +: VAW] !== 39'h5000) begin n_fail++; $display("FAIL release_pc: got %h expected 5000", out_pc_m1[0 +: VAW]); end
    n_checks++; if (out_npc_m1[0 +: VAW] !== 39'h6000) begin n_fail++; $display("FAIL release_npc: got %h expected 6000", out_npc_m1[0 +: VAW]); end
    clr_in(); tick();
  endtask

  task automatic test_ras_overflow();
    logic [VAW-1:0] p;
    out_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      clr_in();
      p = 39'h7000 + 39'(k * 16);
      set_slot(0, p, T_CALL_JAL, 1'b0, 1'b0, 39'h8000);
      tick();
    end
    clr_in(); cmt_push = 1'b1; tick(); tick();
    cmt_push = 1'b0; flush = 1'b1; tick();
    clr_in(); set_slot(0, 39'h8000, T_RET, 1'b0, 1'b0, 39'h0);
    #1;
    n_checks++; if (bp_addr_m1 !== 39'h7014) begin n_fail++; $display("FAIL ovf_ret1: got %h expected 7014", bp_addr_m1); end
    tick();
    #1;
    n_checks++; if (bp_addr_m1 !== 39'h7084) begin n_fail++; $display("FAIL ovf_ret2_wrap: got %h expected 7084", bp_addr_m1); end
    tick();
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL ovf_ret3_empty: got %0b expected 0", bp_vld_m1); end
    tick(); clr_in(); tick();
  endtask

  task automatic test_fire_flush();
    clr_in(); out_rdy = 1'b1;
    set_slot(0, 39'h9000, T_NONE, 1'b0, 1'b0, 39'h0);
    tick();
    clr_in(); set_slot(0, 39'h9100, T_CALL_JAL, 1'b0, 1'b0, 39'hA000); flush = 1'b1;
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL ff_bp_vld: got %0b expected 0", bp_vld_m1); end
    tick();
    n_checks++; if (out_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL ff_out_vld: got %0b expected 0", out_vld_m1); end
    n_checks++; if (out_pc_m1[0 +: VAW] !== 39'h9000) begin n_fail++; $display("FAIL ff_no_load: got %h expected 9000", out_pc_m1[0 +: VAW]); end
    clr_in(); set_slot(0, 39'h8000, T_RET, 1'b0, 1'b0, 39'h0);
    #1;
    n_checks++; if (bp_addr_m1 !== 39'h7014) begin n_fail++; $display("FAIL ff_ras_top: got %h expected 7014", bp_addr_m1); end
    tick();
    #1;
    n_checks++; if (bp_addr_m1 !== 39'h7084) begin n_fail++; $display("FAIL ff_ras_next: got %h expected 7084", bp_addr_m1); end
    tick(); clr_in(); tick();
  endtask

  task automatic test_bht();
    clr_in(); out_rdy = 1'b1;
    set_slot(0, 39'h1008, T_BRANCH, 1'b0, 1'b0, 39'h0F00);
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL bht_init: got %0b expected 0", bp_vld_m1); end
    tick();
    clr_in(); bht_upd_vld = 1'b1; bht_upd_pc = 39'h1008; bht_upd_taken = 1'b1;
    tick(); tick();
    clr_in(); set_slot(0, 39'h1008, T_BRANCH, 1'b0, 1'b0, 39'h0F00);
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b1) begin n_fail++; $display("FAIL bht_taken: got %0b expected 1", bp_vld_m1); end
    n_checks++; if (bp_addr_m1 !== 39'h0F00) begin n_fail++; $display("FAIL bht_addr: got %h expected f00", bp_addr_m1); end
    n_checks++; if (bp_vld_m0 !== 1'b0) begin n_fail++; $display("FAIL static_fwd: got %0b expected 0", bp_vld_m0); end
    tick();
    n_checks++; if (out_npc_m1[0 +: VAW] !== 39'h0F00) begin n_fail++; $display("FAIL bht_npc: got %h expected f00", out_npc_m1[0 +: VAW]); end
    n_checks++; if (out_npc_m0[0 +: VAW] !== 39'h100C) begin n_fail++; $display("FAIL static_npc: got %h expected 100c", out_npc_m0[0 +: VAW]); end
    bht_upd_vld = 1'b1; bht_upd_pc = 39'h1008; bht_upd_taken = 1'b0;
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b1) begin n_fail++; $display("FAIL bht_rd_old: got %0b expected 1", bp_vld_m1); end
    tick();
    clr_in(); bht_upd_vld = 1'b1; bht_upd_pc = 39'h1008; bht_upd_taken = 1'b0;
    tick();
    clr_in(); set_slot(0, 39'h1008, T_BRANCH, 1'b0, 1'b0, 39'h0F00);
    #1;
    n_checks++; if (bp_vld_m1 !== 1'b0) begin n_fail++; $display("FAIL bht_decay: got %0b expected 0", bp_vld_m1); end
    tick();
    clr_in(); set_slot(0, 39'h1008, T_BRANCH, 1'b0, 1'b1, 39'h0F00);
    #1;
    n_checks++; if (bp_vld_m0 !== 1'b1) begin n_fail++; $display("FAIL static_bwd: got %0b expected 1", bp_vld_m0); end
    n_checks++; if (bp_addr_m0 !== 39'h0F00) begin n_fail++; $display("FAIL static_bwd_addr: got %h expected f00", bp_addr_m0); end
    tick(); clr_in(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    out_rdy = 1'b0;
    rst_n   = 1'b0;
    #12;
    test_reset();
    #1 rst_n = 1'b1;
    tick();
    test_jump();
    test_jalr();
    test_call_ret();
    test_back_to_back();
    test_ras_overflow();
    test_fire_flush();
    test_bht();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
